// File: rtl/serdes_tx_scheduler.sv
// Round-robin 4-channel arbiter feeding one byte frame at a time to a serializer; ser_start follows accept by 1 cycle.
// req_ready is held low until ser_done (or, with SERDES_SCHED_TIMEOUT_EN defined, the WAIT watchdog) returns the FSM to IDLE.
module serdes_tx_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic        ser_start,
    output logic [9:0]  ser_word,
    input  logic        ser_done,
    output logic [1:0]  active_ch,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        timeout_err
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("serdes_tx_scheduler: TIMEOUT_CYCLES must be within 2..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [9:0]  ser_word_q, ser_word_d;
    logic [1:0]  active_ch_q, active_ch_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        timeout_err_q, timeout_err_d;
    logic [3:0]  req_ready_c;

    logic [1:0]  grant;
    logic        grant_vld;
    logic [1:0]  search_idx;

`ifdef SERDES_SCHED_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt_q, wait_cnt_d;
`endif

    // Search starts one past the previous winner so every channel gets a turn.
    always_comb begin
        grant      = 2'd0;
        grant_vld  = 1'b0;
        search_idx = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            search_idx = last_grant_q + 2'(i);
            if (!grant_vld && req_valid[search_idx]) begin
                grant     = search_idx;
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        ser_word_d    = ser_word_q;
        active_ch_d   = active_ch_q;
        frame_cnt_d   = frame_cnt_q;
        timeout_err_d = 1'b0;
        req_ready_c   = 4'b0000;
`ifdef SERDES_SCHED_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    req_ready_c[grant] = 1'b1;
                    ser_word_d         = {grant, req_data[{grant, 3'b000} +: 8]};
                    active_ch_d        = grant;
                    last_grant_d       = grant;
                    state_d            = START;
                end
            end
            START: begin
                state_d = WAIT;
`ifdef SERDES_SCHED_TIMEOUT_EN
                wait_cnt_d = 8'd0;
`endif
            end
            WAIT: begin
                if (ser_done) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = IDLE;
                end
`ifdef SERDES_SCHED_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // last_grant resets to 3 so the first search after reset begins at channel 0.
    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            state_q       <= IDLE;
            last_grant_q  <= 2'd3;
            ser_word_q    <= 10'd0;
            active_ch_q   <= 2'd0;
            frame_cnt_q   <= 16'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            ser_word_q    <= ser_word_d;
            active_ch_q   <= active_ch_d;
            frame_cnt_q   <= frame_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef SERDES_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    // The accept strobe is combinational, so reset must mask it directly.
    assign req_ready = nreset ? 4'b0000 : req_ready_c;
    assign ser_start = (state_q == START);
    assign busy      = (state_q == START) || (state_q == WAIT);
    assign ser_word  = ser_word_q;
    assign active_ch = active_ch_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// Directed bench for serdes_tx_scheduler: expected serializer words are queued at accept and popped at ser_start.
module tb_serdes_tx_scheduler;

    logic        clk = 1'b0;
    logic        nreset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        ser_start;
    logic [9:0]  ser_word;
    logic        ser_done;
    logic [1:0]  active_ch;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        timeout_err;

    int          tests = 0;
    int          fails = 0;
    logic [9:0]  exp_q[$];
    logic [9:0]  cur_word;
    logic [15:0] exp_frames;

    always #5 clk = ~clk;

    serdes_tx_scheduler #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .ser_start   (ser_start),
        .ser_word    (ser_word),
        .ser_done    (ser_done),
        .active_ch   (active_ch),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one request in an IDLE cycle, checks the grant, then checks the START cycle.
    task automatic accept(input logic [3:0] vld, input logic [31:0] data, input logic [1:0] ch,
                          input bit hold, input bit done_in_start);
        logic [3:0] exp_rdy;
        @(posedge clk); #1;
        ser_done  = 1'b0;
        req_valid = vld;
        req_data  = data;
        @(negedge clk);
        exp_rdy = 4'b0001 << ch;
        check("idle_busy", busy, 0);
        check("idle_frame_cnt", frame_cnt, exp_frames);
        check("req_ready_grant", req_ready, exp_rdy);
        exp_q.push_back({ch, data[{ch, 3'b000} +: 8]});
        @(posedge clk); #1;
        if (!hold) req_valid = 4'b0000;
        ser_done = done_in_start;
        @(negedge clk);
        cur_word = exp_q.pop_front();
        check("ser_start", ser_start, 1);
        check("ser_word", ser_word, cur_word);
        check("active_ch", active_ch, ch);
        check("req_ready_start", req_ready, 0);
    endtask

    // Pulses ser_done done_delay cycles after the START cycle; word must stay stable meanwhile.
    task automatic finish(input int done_delay);
        for (int k = 1; k < done_delay; k++) begin
            @(posedge clk); #1;
            ser_done = 1'b0;
            @(negedge clk);
            check("wait_busy", busy, 1);
            check("wait_ser_word_stable", ser_word, cur_word);
        end
        @(posedge clk); #1;
        ser_done = 1'b1;
        @(negedge clk);
        check("done_cycle_busy", busy, 1);
        check("done_cycle_start_low", ser_start, 0);
        exp_frames = exp_frames + 16'd1;
    endtask

    task automatic idle_step();
        @(posedge clk); #1;
        ser_done  = 1'b0;
        req_valid = 4'b0000;
        @(negedge clk);
        check("idle_step_busy", busy, 0);
        check("idle_step_frame_cnt", frame_cnt, exp_frames);
        check("idle_step_timeout_err", timeout_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset     = 1'b1;
        req_valid  = 4'b0000;
        req_data   = 32'd0;
        ser_done   = 1'b0;
        exp_frames = 16'd0;
        cur_word   = 10'd0;
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_ser_start", ser_start, 0);
        check("rst_ser_word", ser_word, 0);
        check("rst_active_ch", active_ch, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_timeout_err", timeout_err, 0);
        @(posedge clk); #1;
        nreset = 1'b0;

        // Single request on channel 2, done 5 cycles after ser_start.
        accept(4'b0100, 32'h00A5_0000, 2'd2, 1'b0, 1'b0);
        check("single_word_2a5", ser_word, 10'h2A5);
        finish(5);
        idle_step();

        // Channel 3 alone, then all four held valid: rotation 0,1,2,3,0 back-to-back.
        accept(4'b1000, 32'h7700_0000, 2'd3, 1'b0, 1'b0);
        finish(1);
        accept(4'b1111, 32'h4433_2211, 2'd0, 1'b1, 1'b0);
        finish(1);
        accept(4'b1111, 32'h4433_2211, 2'd1, 1'b1, 1'b0);
        finish(2);
        accept(4'b1111, 32'h4433_2211, 2'd2, 1'b1, 1'b0);
        finish(1);
        accept(4'b1111, 32'h4433_2211, 2'd3, 1'b1, 1'b0);
        finish(3);
        accept(4'b1111, 32'h4433_2211, 2'd0, 1'b1, 1'b0);
        finish(1);
        idle_step();

        // Spurious ser_done in IDLE and in START must be ignored.
        @(posedge clk); #1;
        ser_done = 1'b1;
        @(negedge clk);
        check("spur_idle_busy", busy, 0);
        check("spur_idle_start", ser_start, 0);
        idle_step();
        accept(4'b0001, 32'h0000_003C, 2'd0, 1'b0, 1'b1);
        finish(3);
        idle_step();

`ifdef SERDES_SCHED_TIMEOUT_EN
        accept(4'b0010, 32'h0000_5A00, 2'd1, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("to_wait_busy", busy, 1);
            check("to_wait_err_low", timeout_err, 0);
        end
        @(negedge clk);
        check("to_err_pulse", timeout_err, 1);
        check("to_back_idle", busy, 0);
        check("to_frame_cnt", frame_cnt, exp_frames);
        @(negedge clk);
        check("to_err_one_cycle", timeout_err, 0);
        // last_grant advanced to 1, so channels 2 and 0 compete and 2 wins; done on the limit cycle wins.
        accept(4'b0101, 32'h00C3_00E1, 2'd2, 1'b0, 1'b0);
        finish(8);
        idle_step();
`else
        accept(4'b0010, 32'h0000_5A00, 2'd1, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("noto_still_wait", busy, 1);
        check("noto_err_low", timeout_err, 0);
        finish(1);
        idle_step();
`endif

        // Reset in the middle of a channel 1 frame.
        accept(4'b0010, 32'h0000_9900, 2'd1, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #3;
        req_valid = 4'b1111;
        nreset    = 1'b1;
        #1;
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_ser_start", ser_start, 0);
        check("mid_rst_ser_word", ser_word, 0);
        check("mid_rst_active_ch", active_ch, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        check("mid_rst_timeout_err", timeout_err, 0);
        exp_frames = 16'd0;
        @(posedge clk); #1;
        nreset    = 1'b0;
        req_valid = 4'b0000;
        accept(4'b1001, 32'hD200_00B4, 2'd0, 1'b0, 1'b0);
        finish(2);
        accept(4'b0010, 32'h0000_6600, 2'd1, 1'b0, 1'b0);
        finish(1);
        idle_step();

        // Counter wrap from 0xFFFF.
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.frame_cnt_q;
        exp_frames = 16'hFFFF;
        @(negedge clk);
        check("wrap_preload", frame_cnt, 16'hFFFF);
        accept(4'b0100, 32'h0081_0000, 2'd2, 1'b0, 1'b0);
        finish(1);
        idle_step();
        check("wrap_zero", frame_cnt, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serdes_tx_scheduler.md
SERDES_TX_SCHEDULER -- requirements
Module: serdes_tx_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, WAIT-state cycles before abandoning a frame; legal range 2..255.
REQ-002 Port: clk  input  1  single clock; all logic rising-edge.
REQ-003 Port: nreset  input  1  reset, asynchronous, active-high.
REQ-004 Port: req_valid  input  4  per-channel request; bit n = channel n.
REQ-005 Port: req_data  input  32  per-channel byte; channel n on bits [8n+7:8n].
REQ-006 Port: req_ready  output  4  accept strobe; one-hot or zero.
REQ-007 Port: ser_start  output  1  one-cycle load strobe to the serializer.
REQ-008 Port: ser_word  output  10  {channel id[1:0], data[7:0]} presented to the serializer.
REQ-009 Port: ser_done  input  1  one-cycle serializer completion pulse.
REQ-010 Port: active_ch  output  2  channel of the frame in flight.
REQ-011 Port: busy  output  1  high in START and WAIT.
REQ-012 Port: frame_cnt  output  16  completed-frame count.
REQ-013 Port: timeout_err  output  1  one-cycle pulse on abandoned frame.

Function
REQ-014 FSM states SHALL be IDLE, START, WAIT.
REQ-015 In IDLE with req_valid != 0, grant SHALL go to the first set bit searching from (last_grant+1) mod 4 upward, wrapping.
REQ-016 req_ready[grant] SHALL be asserted combinationally in that IDLE cycle only; ser_word, active_ch and last_grant SHALL be registered on that edge; the next state SHALL be START.
REQ-017 In IDLE with req_valid == 0, req_ready SHALL be 0 and the FSM SHALL stay in IDLE.
REQ-018 START SHALL last exactly one cycle with ser_start=1; the next state SHALL be WAIT; latency from accept to ser_start SHALL be 1 cycle.
REQ-019 ser_word SHALL be held stable from START until the FSM returns to IDLE.
REQ-020 ser_done SHALL be sampled only in WAIT; a pulse in IDLE or START SHALL be ignored.
REQ-021 WAIT with ser_done=1 SHALL increment frame_cnt (wrapping 0xFFFF->0x0000) and return to IDLE.
REQ-022 Back-to-back: the IDLE cycle after WAIT SHALL be able to accept, giving a 3-cycle minimum frame period plus serializer time.
REQ-023 Deasserting req_valid while not granted SHALL be permitted; the grant SHALL use only the current-cycle req_valid.
REQ-024 With all four channels continuously valid, grants SHALL rotate 0,1,2,3,0.

Reset
REQ-025 Asserting nreset SHALL immediately force: state IDLE, last_grant=3, req_ready=0, ser_start=0, ser_word=0, active_ch=0, busy=0, frame_cnt=0, timeout_err=0, wait counter=0.
REQ-026 Reset during START or WAIT SHALL abandon the frame without counting it; the first grant after release SHALL search from channel 0.

Configuration
REQ-027 The macro SERDES_SCHED_TIMEOUT_EN SHALL control the WAIT watchdog.
REQ-028 When it is defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-029 When it is defined and the counter reaches TIMEOUT_CYCLES without ser_done, the block SHALL pulse timeout_err for one cycle, return to IDLE, and leave frame_cnt unchanged; last_grant SHALL remain advanced.
REQ-030 When it is defined and ser_done arrives in the same cycle the count is reached, ser_done SHALL win.
REQ-031 When it is not defined, WAIT SHALL persist until ser_done, timeout_err SHALL be tied 0, and no counter SHALL be synthesized.

Verification
REQ-032 Single request: req_valid=4'b0100, ch2 data 0xA5, ser_done 5 cycles after ser_start -> req_ready=4'b0100 for 1 cycle, ser_start next cycle, ser_word=10'h2A5, frame_cnt=1.
REQ-033 Contention: req_valid=4'b1111 held for 4 frames -> grant order 0,1,2,3; ser_word ids 0,1,2,3.
REQ-034 Spurious done: ser_done pulsed in IDLE and in START -> no state change; frame_cnt unchanged.
REQ-035 Timeout (macro defined, TIMEOUT_CYCLES=8): ser_done never asserted -> timeout_err pulse 8 cycles after WAIT entry, return to IDLE, frame_cnt unchanged; without the macro -> FSM stays in WAIT indefinitely.
REQ-036 Reset mid-WAIT: nreset pulsed during a ch1 frame -> all outputs 0 asynchronously; a subsequent req_valid=4'b0010 is granted to ch1; frame_cnt restarts at 0.
REQ-037 Wrap: preload 0xFFFF completions -> the next done yields frame_cnt=0x0000.
